// File: rtl/color_pkg.sv
// Shared colour types and constants for the Pong VGA colour compositor.
package color_pkg;

  localparam int COLOR_W = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = '{r: '0, g: '0, b: '0};
  localparam rgb_t RGB_WHITE  = '{r: '1, g: '1, b: '1};
  localparam rgb_t RGB_YELLOW = '{r: '1, g: '1, b: '0};
  localparam rgb_t RGB_CYAN   = '{r: '0, g: '1, b: '1};

  // Palette index width: one entry per layer plus the background entry.
  function automatic int pal_idx_w(input int num_layers);
    return $clog2(num_layers + 1);
  endfunction

endpackage

// File: rtl/color_compositor_if.sv
// Pixel, palette and flash signals between the sprite hit logic, the compositor and the VGA pins.
interface color_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = color_pkg::COLOR_W
) ();
  localparam int IDX_W = color_pkg::pal_idx_w(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] layer_hit;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  blank_in;
  logic                  frame_start;
  logic                  pal_we;
  logic [IDX_W-1:0]      pal_idx;
  logic [3*COLOR_W-1:0]  pal_rgb;
  logic                  flash_req;
  logic [COLOR_W-1:0]    R;
  logic [COLOR_W-1:0]    G;
  logic [COLOR_W-1:0]    B;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  blank_out;
  logic                  flash_active;

  modport master (
    output layer_hit, hsync_in, vsync_in, blank_in, frame_start,
           pal_we, pal_idx, pal_rgb, flash_req,
    input  R, G, B, hsync_out, vsync_out, blank_out, flash_active
  );

  modport slave (
    input  layer_hit, hsync_in, vsync_in, blank_in, frame_start,
           pal_we, pal_idx, pal_rgb, flash_req,
    output R, G, B, hsync_out, vsync_out, blank_out, flash_active
  );

endinterface

// File: rtl/prio_enc.sv
// Combinational lowest-set-bit priority encoder: bit 0 wins.
module prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_compositor.sv
// Two-stage layer-priority colour compositor with runtime palette and delay-matched VGA sync.
// Optional inverse-video flash is built when COLOR_COMPOSITOR_FLASH_EN is defined.
module color_compositor
  import color_pkg::pal_idx_w;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = color_pkg::COLOR_W,
  parameter int FLASH_FRAMES = 15
) (
  input  logic               clock,
  input  logic               reset,
  color_compositor_if.slave  bus
);

  localparam int IDX_W = pal_idx_w(NUM_LAYERS);
  localparam int BG    = NUM_LAYERS;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  localparam logic [COLOR_W-1:0] C_MAX  = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;
  localparam pix_t PIX_BLACK  = '{C_ZERO, C_ZERO, C_ZERO};
  localparam pix_t PIX_WHITE  = '{C_MAX,  C_MAX,  C_MAX};
  localparam pix_t PIX_YELLOW = '{C_MAX,  C_MAX,  C_ZERO};
  localparam pix_t PIX_CYAN   = '{C_ZERO, C_MAX,  C_MAX};

  logic [IDX_W-1:0] w_hit_idx;
  logic             w_hit_any;
  logic             w_flash_active;
  pix_t             w_lookup;

  logic             r_s1_hit;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_hsync;
  logic             r_s1_vsync;
  logic             r_s1_blank;
  pix_t             r_pal [NUM_LAYERS+1];
  pix_t             r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;

  prio_enc #(.N(NUM_LAYERS), .IW(IDX_W)) u_prio_enc (
    .req (bus.layer_hit),
    .idx (w_hit_idx),
    .any (w_hit_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_hit   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
      r_s1_blank <= 1'b1;
    end else begin
      r_s1_hit   <= w_hit_any;
      r_s1_idx   <= w_hit_idx;
      r_s1_hsync <= bus.hsync_in;
      r_s1_vsync <= bus.vsync_in;
      r_s1_blank <= bus.blank_in;
    end
  end

  // NOTE: the palette is a small register file with defined reset colours, so it is reset like any flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NUM_LAYERS; i++) begin
        if (i == BG)     r_pal[i] <= PIX_BLACK;
        else if (i == 0) r_pal[i] <= PIX_YELLOW;
        else if (i == 1) r_pal[i] <= PIX_CYAN;
        else             r_pal[i] <= PIX_WHITE;
      end
    end else if (bus.pal_we && (int'(bus.pal_idx) <= BG)) begin
      r_pal[bus.pal_idx] <= pix_t'(bus.pal_rgb);
    end
  end

  // Reads the pre-edge palette, so a same-edge write is seen one pixel later.
  assign w_lookup = r_s1_hit ? r_pal[r_s1_idx] : r_pal[BG];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rgb   <= PIX_BLACK;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blank <= 1'b1;
    end else begin
      if (r_s1_blank)          r_rgb <= PIX_BLACK;
      else if (w_flash_active) r_rgb <= pix_t'(~w_lookup);
      else                     r_rgb <= w_lookup;
      r_hsync <= r_s1_hsync;
      r_vsync <= r_s1_vsync;
      r_blank <= r_s1_blank;
    end
  end

`ifdef COLOR_COMPOSITOR_FLASH_EN
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [CNT_W-1:0] r_flash_cnt;

  // A request reloads the count and swallows a coincident frame_start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flash_cnt <= '0;
    end else if (bus.flash_req) begin
      r_flash_cnt <= CNT_W'(FLASH_FRAMES);
    end else if (bus.frame_start && (r_flash_cnt != '0)) begin
      r_flash_cnt <= r_flash_cnt - CNT_W'(1);
    end
  end

  assign w_flash_active = (r_flash_cnt != '0);
`else
  logic w_unused_flash;

  assign w_flash_active = 1'b0;
  assign w_unused_flash = bus.flash_req ^ bus.frame_start ^ FLASH_FRAMES[0];
`endif

  assign bus.R            = r_rgb.r;
  assign bus.G            = r_rgb.g;
  assign bus.B            = r_rgb.b;
  assign bus.hsync_out    = r_hsync;
  assign bus.vsync_out    = r_vsync;
  assign bus.blank_out    = r_blank;
  assign bus.flash_active = w_flash_active;

endmodule
